// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The TRAP encoding is reachable only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    TRAP  = 2'd3
  } state_t;

  // Source selector for the next program counter value.
  typedef enum logic [1:0] {
    NPC_HOLD    = 2'd0,
    NPC_INC     = 2'd1,
    NPC_TARGET  = 2'd2,
    NPC_PENDING = 2'd3
  } npc_sel_t;

  localparam logic [31:0] NOP    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux over pc+4, redirect target,
// pending target and hold, plus the redirect alignment check.
// FETCH_MISALIGN_TRAP_EN defined: targets pass unmodified and a target with
// bits[1:0] != 0 is flagged. Undefined: bits[1:0] are forced to zero and the
// flag is constant 0.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] redirect_target,
  input  logic [31:0] pending_target,
  output logic [31:0] next_pc,
  output logic        redirect_misaligned
);

  logic [31:0] redirect_eff;
  logic [31:0] pending_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_eff        = redirect_target;
  assign pending_eff         = pending_target;
  assign redirect_misaligned = |redirect_target[1:0];
`else
  // A misaligned target fetches the word that contains it.
  logic unused_low_bits;
  assign unused_low_bits     = ^{redirect_target[1:0], pending_target[1:0]};
  assign redirect_eff        = {redirect_target[31:2], 2'b00};
  assign pending_eff         = {pending_target[31:2], 2'b00};
  assign redirect_misaligned = 1'b0;
`endif

  // Pick the next PC; pc+4 wraps naturally in 32-bit unsigned arithmetic.
  always_comb begin
    // NOTE: every path assigns next_pc (the default arm holds), so no latch is inferred.
    case (npc_sel_t'(sel))
      NPC_INC:     next_pc = pc + PC_INC;
      NPC_TARGET:  next_pc = redirect_eff;
      NPC_PENDING: next_pc = pending_eff;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Owns the PC, runs one
// req/ack transaction per instruction and hands each word with its PC to
// decode over valid/ready. Redirects that supersede an in-flight fetch park
// the target in DRAIN until the stale ack returns.
// Optional feature FETCH_MISALIGN_TRAP_EN: misaligned redirect targets lead to
// a sticky TRAP state (left only by rst) that raises fetch_misaligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_misaligned
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pending_target;
  logic        pending_mis;
  logic        redirect_mis;
  logic        ack_fire;
  logic        consume;
  logic [1:0]  npc_sel;

  assign imem_addr = pc;
  // DRAIN keeps the stale request alive; FETCH requests when the output slot frees up.
  assign imem_req  = (state == DRAIN) ||
                     ((state == FETCH) && (!inst_valid || inst_ready));
  assign ack_fire  = imem_req && imem_ack;
  assign consume   = inst_valid && inst_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = (state == TRAP);
`else
  assign fetch_misaligned = 1'b0;
`endif

  // Choose the PC source from state and the redirect > ack priority.
  always_comb begin
    npc_sel = NPC_HOLD;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          // An unacked request keeps its address; the target waits in DRAIN.
          if ((ack_fire || !imem_req) && !redirect_mis) npc_sel = NPC_TARGET;
        end else if (ack_fire) begin
          npc_sel = NPC_INC;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            if (!redirect_mis) npc_sel = NPC_TARGET;
          end else if (!pending_mis) begin
            npc_sel = NPC_PENDING;
          end
        end
      end
      default: npc_sel = NPC_HOLD;
    endcase
  end

  next_pc_sel u_next_pc_sel (
    .sel                 (npc_sel),
    .pc                  (pc),
    .redirect_target     (redirect_target),
    .pending_target      (pending_target),
    .next_pc             (next_pc),
    .redirect_misaligned (redirect_mis)
  );

  // FSM, PC register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state          <= BOOT;
      pc             <= RESET_PC;
      pending_target <= RESET_PC;
      pending_mis    <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= NOP;
      inst_pc        <= RESET_PC;
    end else begin
      pc <= next_pc;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              pending_target <= redirect_target;
              pending_mis    <= redirect_mis;
              state          <= DRAIN;
            end else if (redirect_mis) begin
              state <= TRAP;
            end
          end else if (ack_fire) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end else if (consume) begin
            inst_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            // The stale word is dropped; the latest target decides where to go.
            if (redirect_valid ? redirect_mis : pending_mis) state <= TRAP;
            else                                             state <= FETCH;
          end else if (redirect_valid) begin
            pending_target <= redirect_target;
            pending_mis    <= redirect_mis;
          end
        end
        default: ;  // TRAP is sticky until rst
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the instruction memory and decoder in the RV32I core. It owns the program counter and drives the instruction memory address. It runs a request/acknowledge transaction per instruction and presents each fetched word, with its PC, to decode through a valid/ready handshake. It accepts branch/jump redirects and handles in-flight fetches that a redirect has superseded.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  32  instruction memory address (current PC)
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ack
- imem_ack  in  1  memory completes the request this cycle; imem_rdata valid
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst/inst_pc hold a fetched instruction
- inst_ready  in  1  decode consumes inst this cycle when inst_valid=1
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst
- redirect_valid  in  1  branch/jump taken; 1-cycle pulse
- redirect_target  in  32  new PC
- fetch_misaligned  out  1  misaligned redirect trap (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise)

## Operation
- States: BOOT, FETCH, DRAIN, TRAP (TRAP only with macro).
- BOOT: entered on rst; imem_req=0; next cycle → FETCH.
- FETCH: imem_req=1 when output register is empty or is being consumed (inst_valid & inst_ready). Otherwise imem_req=0 and the PC is held.
- On imem_ack in FETCH with no redirect: inst←imem_rdata, inst_pc←pc, inst_valid←1, pc←pc+4.
- Consumption without a new ack: inst_valid←0.
- Redirect in FETCH, ack same cycle: data discarded, inst_valid←0, pc←target, stay FETCH.
- Redirect in FETCH, request outstanding without ack: inst_valid←0. Latch target as pending and → DRAIN. imem_req and imem_addr stay unchanged until ack.
- Redirect in FETCH, no request outstanding: inst_valid←0, pc←target.
- DRAIN: imem_req=1 at the old address. On ack, discard the data, pc←pending target, → FETCH.
- Redirect arriving in DRAIN overwrites the pending target (latest wins).
- PC arithmetic: unsigned 32-bit, pc+4 wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Priority: rst > redirect > ack > consumption.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_misaligned=0.
- First imem_req: second cycle after the rst-high cycle. The first cycle is spent in BOOT.
- Latency: ack in cycle n → inst_valid=1 in cycle n+1.
- Zero-wait memory (ack with req) with inst_ready held high sustains 1 instruction per cycle.
- Redirect in cycle n with no outstanding request: imem_addr=target in cycle n+1.
- inst, inst_pc stable while inst_valid & !inst_ready.
- rst mid-DRAIN: outstanding transaction abandoned; any ack after reset is ignored in BOOT.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect_target with bits[1:0]≠0 moves the block to TRAP instead of fetching.
  - TRAP: imem_req=0, inst_valid=0, fetch_misaligned=1.
  - TRAP is left only by rst.
  - An outstanding request is first drained; the block enters TRAP after the ack.
- FETCH_MISALIGN_TRAP_EN undefined: target bits[1:0] forced to 0; fetch_misaligned constant 0; no TRAP state.

## Structure
- Shared package fetch_pkg:
  - state enum (BOOT, FETCH, DRAIN, TRAP)
  - NOP constant 32'h0000_0013
  - PC_INC = 4
- One sub-module: next_pc_sel, a combinational mux over pc+4, redirect target, pending target and hold, with the alignment check.
- PC register, output register and FSM stay in fetch_unit.

## Test plan
- Reset release with RESET_PC=32'h100, ack tied to req, ready=1 → imem_addr 0x100, 0x104, 0x108 on consecutive cycles. inst_pc lags imem_addr by one cycle.
- inst_ready=0 for 3 cycles after first valid → inst/inst_pc frozen, imem_req=0, PC held. Ready high → next fetch in the same cycle.
- Ack delayed 2 cycles; redirect to 0x200 in the first wait cycle:
  - DRAIN entered; old word discarded after ack.
  - Next request is at 0x200; inst_valid never shows the old word.
- Redirect and ack in the same cycle → data dropped, next imem_addr=target, no DRAIN.
- PC=32'hFFFF_FFFC fetched → next imem_addr 32'h0.
- FETCH_MISALIGN_TRAP_EN, redirect to 0x202 → fetch_misaligned=1, imem_req=0 until rst. Without the macro the next fetch address is 0x200.
